jtframe_ioctl_conv: RTL and testbench
=====================================

// Module: jtframe_ioctl_conv
// PURPOSE
//  Parametrised ioctl download converter between hps_io and the JTFRAME board/SDRAM loader.
//  Splits DIN_W-bit download words into byte writes spaced GAP cycles apart, with a one-word pending buffer.
//  Routes bytes by ioctl_index: ROM load, MRA DIP bytes, or core_mod.
//  Replaces the fixed 16-to-8 FASTIO splitter and the fixed 32-bit DIP capture.
// PARAMETERS
//  DIN_W      16          download word width: 8, 16 or 32; BYTES = DIN_W/8
//  GAP        24          minimum cycles between consecutive ioctl_wr pulses, >=1
//  DIP_BYTES  4           DIP bytes captured, 1..8
//  DIP_DEF    all-ones    dipsw reset value, width 8*DIP_BYTES
//  ROM_INDEX  8'd0        index routed to ioctl_rom_wr
//  MOD_INDEX  8'd1        index routed to core_mod
//  DIP_INDEX  8'd254      index routed to dipsw
// PORTS
//  clk_rom         in   1             download clock
//  rst_n           in   1             asynchronous, active-low reset
//  ioctl_download  in   1             hps_io download active
//  ioctl_index     in   8             hps_io download index
//  dwnld_wr        in   1             one-cycle word strobe from hps_io
//  dwnld_addr      in   27            byte address of word; low log2(BYTES) bits ignored
//  dwnld_data      in   DIN_W         word; byte 0 at [7:0]
//  ioctl_wr        out  1             one-cycle byte strobe, any index
//  ioctl_addr      out  25            byte address
//  ioctl_data      out  8             byte data
//  ioctl_rom_wr    out  1             ioctl_wr gated by index==ROM_INDEX
//  dipsw           out  8*DIP_BYTES   captured DIP bytes; byte n at [8n+7:8n]
//  core_mod        out  7             core mode bits
//  busy            out  1             high while the FSM is not IDLE or the pending buffer is full
//  overrun         out  1             sticky word-drop flag
// BEHAVIOUR
//  Reset values: ioctl_wr=0, ioctl_addr=0, ioctl_data=0, ioctl_rom_wr=0, dipsw=DIP_DEF,
//   core_mod=7'h7F, busy=0, overrun=0. Reset mid-operation drops the active and pending words.
//  The index is sampled with each accepted word and held with that word.
//  FSM states:
//   IDLE: on dwnld_wr, latch word, address and index; go to EMIT.
//   EMIT: pulse ioctl_wr for byte k (k starts at 0).
//    ioctl_addr = {dwnld_addr[24:log2(BYTES)], k}; ioctl_data = word[8k+7:8k].
//    If k==BYTES-1 and no pending word: go to WAIT_LAST, then to IDLE after GAP-1 cycles.
//    Otherwise go to WAIT.
//   WAIT: count GAP-1 cycles, then go to EMIT with the next byte.
//    If the last byte is done, load the pending word with k=0.
//  Latency: dwnld_wr at cycle t gives byte k at t+1+k*GAP. Consecutive pulses are never closer than GAP cycles.
//  DIN_W=8: GAP is ignored. Every word is a registered pass-through with 1-cycle latency; the pending buffer is unused.
//  Pending buffer, one word:
//   dwnld_wr while busy stores the word in pending.
//   dwnld_wr while pending is full drops the word and sets overrun.
//   If the pending slot is freed and a new dwnld_wr arrives in the same cycle, the word is accepted into pending.
//  overrun clears on the rising edge of ioctl_download only.
//  DIP capture: on a byte write with index==DIP_INDEX and ioctl_addr<DIP_BYTES,
//   dipsw[8*addr+:8] <= data. Addresses >= DIP_BYTES are ignored.
//  core_mod: on a byte write with index==MOD_INDEX and ioctl_addr==0, core_mod <= data[6:0].
//   Other addresses are ignored, so the upper halves of wide words cannot overwrite byte 0.
//  ioctl_download falling while words remain: all queued bytes are still emitted and routed.
// CONFIGURATION
//  JTFRAME_IOCTL_CHKSUM_EN defined:
//   Extra output port chksum, 16 bits, reset value 0.
//   Cleared on the ioctl_download rising edge.
//   On every ioctl_rom_wr, chksum <= chksum + ioctl_data, wrapping mod 2^16.
//   The value is read by the board after ioctl_download falls.
//  JTFRAME_IOCTL_CHKSUM_EN undefined: the port and its logic are absent.
// TESTING
//  1. DIN_W=16, GAP=24, index 0: word 16'hBEEF at addr 0x100, dwnld_wr at t.
//     -> ioctl_rom_wr at t+1 with addr 0x100 and data 8'hEF; at t+25 with addr 0x101 and data 8'hBE.
//  2. Same configuration: second dwnld_wr at t+5 with 16'h1234.
//     -> busy=1; bytes 8'h34 and 8'h12 emitted at t+49 and t+73; overrun stays 0.
//  3. Third dwnld_wr at t+6 while pending is full.
//     -> word dropped; overrun=1; overrun held until the next ioctl_download rise.
//  4. Index 254, DIN_W=32: word 32'h04030201 at addr 0.
//     -> dipsw=32'h04030201 after 4 pulses; ioctl_rom_wr stays 0 throughout.
//  5. Index 1, DIN_W=16: word 16'hFF05 at addr 0.
//     -> core_mod=7'h05; the byte at addr 1 leaves core_mod unchanged.
//  6. Assert rst_n=0 between bytes 0 and 1 of a ROM word.
//     -> no further ioctl_wr; dipsw=DIP_DEF; core_mod=7'h7F; chksum (if enabled)=0;
//     ROM bytes 1,2,3 then give chksum=16'h0006.

Source files
------------

// File: rtl/jtframe_ioctl_conv.sv
// jtframe_ioctl_conv
// Converts hps_io download words (DIN_W bits) into byte writes at least GAP
// cycles apart. A one-word pending buffer absorbs a word that arrives while
// the current one is still being emitted. Each word carries its own
// ioctl_index, which routes its bytes to the ROM loader, the DIP switches
// or core_mod.
// Optional feature: define JTFRAME_IOCTL_CHKSUM_EN to add the 16-bit output
// chksum, a running sum of every ROM byte written since download start.
module jtframe_ioctl_conv #(
   parameter int                     DIN_W     = 16,
   parameter int                     GAP       = 24,
   parameter int                     DIP_BYTES = 4,
   parameter logic [8*DIP_BYTES-1:0] DIP_DEF   = '1,
   parameter logic [7:0]             ROM_INDEX = 8'd0,
   parameter logic [7:0]             MOD_INDEX = 8'd1,
   parameter logic [7:0]             DIP_INDEX = 8'd254
) (
   input  logic                   clk_rom,
   input  logic                   rst_n,
   input  logic                   ioctl_download,
   input  logic [7:0]             ioctl_index,
   input  logic                   dwnld_wr,
   input  logic [26:0]            dwnld_addr,
   input  logic [DIN_W-1:0]       dwnld_data,
   output logic                   ioctl_wr,
   output logic [24:0]            ioctl_addr,
   output logic [7:0]             ioctl_data,
   output logic                   ioctl_rom_wr,
   output logic [8*DIP_BYTES-1:0] dipsw,
   output logic [6:0]             core_mod,
   output logic                   busy,
   output logic                   overrun
`ifdef JTFRAME_IOCTL_CHKSUM_EN
   ,
   output logic [15:0]            chksum
`endif
);

   localparam int BYTES   = DIN_W / 8;
   localparam int KW      = (BYTES > 1) ? $clog2(BYTES) : 1;
   // An 8-bit word is a plain pass-through, so the spacing rule does not apply
   localparam int GAP_EFF = (DIN_W == 8) ? 1 : GAP;
   localparam int CW      = (GAP_EFF > 2) ? $clog2(GAP_EFF) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((GAP_EFF >= 2) ? GAP_EFF - 2 : 0);
   localparam logic [KW-1:0] K_LAST   = KW'(BYTES - 1);
   localparam logic [24:0]   LOW_MASK = 25'(BYTES - 1);

   typedef enum logic [1:0] {IDLE, EMIT, WAIT, WAIT_LAST} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [KW-1:0]    k_reg;
   logic [DIN_W-1:0] word_reg;
   logic [24:0]      base_reg;
   logic [7:0]       idx_reg;

   logic             pend_full;
   logic [DIN_W-1:0] pend_word;
   logic [24:0]      pend_base;
   logic [7:0]       pend_idx;
   logic             dl_last;

   logic [1:0]       unused_addr;
   assign unused_addr = dwnld_addr[26:25];

   // Word-level address: the low bits select the byte and come from k
   logic [24:0] in_base;
   assign in_base = dwnld_addr[24:0] & ~LOW_MASK;

   logic last, cnt_zero, slot_new, slot_byte;
   logic take_pend, take_in, launch, store_pend, drop, dl_rise;
   assign last      = (k_reg == K_LAST);
   assign cnt_zero  = (cnt_reg == '0);
   // A new word may start: idle, or the gap after the final byte has elapsed
   assign slot_new  = (state_reg == IDLE)
                    || (((state_reg == WAIT) || (state_reg == WAIT_LAST)) && cnt_zero && last)
                    || ((state_reg == EMIT) && (GAP_EFF == 1) && last);
   // The next byte of the current word is due
   assign slot_byte = ((state_reg == WAIT) && cnt_zero && !last)
                    || ((state_reg == EMIT) && (GAP_EFF == 1) && !last);
   assign take_pend  = slot_new && pend_full;
   assign take_in    = slot_new && !pend_full && dwnld_wr;
   assign launch     = take_pend || take_in;
   // The pending slot takes the word if it is empty or is being drained now
   assign store_pend = dwnld_wr && !take_in && (!pend_full || take_pend);
   assign drop       = dwnld_wr && !take_in && pend_full && !take_pend;
   assign dl_rise    = ioctl_download && !dl_last;

   logic [DIN_W-1:0] src_word;
   logic [24:0]      src_base;
   logic [7:0]       src_idx;
   logic [KW-1:0]    k_nxt;
   logic [7:0]       next_data;
   assign src_word  = take_pend ? pend_word : dwnld_data;
   assign src_base  = take_pend ? pend_base : in_base;
   assign src_idx   = take_pend ? pend_idx  : ioctl_index;
   assign k_nxt     = k_reg + KW'(1);
   assign next_data = 8'(word_reg >> {k_nxt, 3'b000});

   assign busy = (state_reg != IDLE) || pend_full;

   // Byte emission FSM with registered strobe, address and data
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         k_reg        <= '0;
         word_reg     <= '0;
         base_reg     <= '0;
         idx_reg      <= '0;
         ioctl_wr     <= 1'b0;
         ioctl_addr   <= '0;
         ioctl_data   <= '0;
         ioctl_rom_wr <= 1'b0;
      end else begin
         ioctl_wr     <= 1'b0;
         ioctl_rom_wr <= 1'b0;
         if (launch) begin
            state_reg    <= EMIT;
            k_reg        <= '0;
            word_reg     <= src_word;
            base_reg     <= src_base;
            idx_reg      <= src_idx;
            ioctl_wr     <= 1'b1;
            ioctl_addr   <= src_base;
            ioctl_data   <= src_word[7:0];
            ioctl_rom_wr <= (src_idx == ROM_INDEX);
         end else if (slot_byte) begin
            state_reg    <= EMIT;
            k_reg        <= k_nxt;
            ioctl_wr     <= 1'b1;
            ioctl_addr   <= base_reg | 25'(k_nxt);
            ioctl_data   <= next_data;
            ioctl_rom_wr <= (idx_reg == ROM_INDEX);
         end else begin
            case (state_reg)
               EMIT: begin
                  if (GAP_EFF == 1) begin
                     state_reg <= IDLE;
                  end else begin
                     state_reg <= (last && !pend_full) ? WAIT_LAST : WAIT;
                     cnt_reg   <= CNT_LOAD;
                  end
               end
               WAIT, WAIT_LAST: begin
                  if (cnt_zero) state_reg <= IDLE;
                  else          cnt_reg   <= cnt_reg - CW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   // One-word pending buffer
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         pend_full <= 1'b0;
         pend_word <= '0;
         pend_base <= '0;
         pend_idx  <= '0;
      end else if (store_pend) begin
         pend_full <= 1'b1;
         pend_word <= dwnld_data;
         pend_base <= in_base;
         pend_idx  <= ioctl_index;
      end else if (take_pend) begin
         pend_full <= 1'b0;
      end
   end

   // Sticky overrun flag, cleared only when a new download starts
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         dl_last <= 1'b0;
         overrun <= 1'b0;
      end else begin
         dl_last <= ioctl_download;
         if (drop)         overrun <= 1'b1;
         else if (dl_rise) overrun <= 1'b0;
      end
   end

   // core_mod only listens to byte 0 so upper word bytes cannot clobber it
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) core_mod <= 7'h7F;
      else if (ioctl_wr && (idx_reg == MOD_INDEX) && (ioctl_addr == '0))
         core_mod <= ioctl_data[6:0];
   end

   genvar gi;
   generate
      for (gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
         logic [7:0] byte_reg;
         // Capture DIP byte gi; addresses past DIP_BYTES match no byte
         always_ff @(posedge clk_rom or negedge rst_n) begin
            if (!rst_n) byte_reg <= DIP_DEF[8*gi +: 8];
            else if (ioctl_wr && (idx_reg == DIP_INDEX) && (ioctl_addr == 25'(gi)))
               byte_reg <= ioctl_data;
         end
         assign dipsw[8*gi +: 8] = byte_reg;
      end
   endgenerate

`ifdef JTFRAME_IOCTL_CHKSUM_EN
   // Running ROM byte sum, restarted with every download
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n)            chksum <= '0;
      else if (dl_rise)      chksum <= '0;
      else if (ioctl_rom_wr) chksum <= chksum + {8'h00, ioctl_data};
   end
`else
   // No checksum logic in this build
`endif

endmodule

// File: tb/tb_jtframe_ioctl_conv.sv
// Directed bench for jtframe_ioctl_conv: 16-bit, 32-bit and 8-bit instances.
module tb_jtframe_ioctl_conv;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dl = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   // 16-bit instance
   logic        a_wr = 1'b0;
   logic [7:0]  a_idx = 8'd0;
   logic [26:0] a_addr = '0;
   logic [15:0] a_data = '0;
   logic        a_owr, a_rom, a_busy, a_ovr;
   logic [24:0] a_oaddr;
   logic [7:0]  a_odata;
   logic [31:0] a_dip;
   logic [6:0]  a_mod;
   // 32-bit instance
   logic        b_wr = 1'b0;
   logic [7:0]  b_idx = 8'd0;
   logic [26:0] b_addr = '0;
   logic [31:0] b_data = '0;
   logic        b_owr, b_rom, b_busy, b_ovr;
   logic [24:0] b_oaddr;
   logic [7:0]  b_odata;
   logic [31:0] b_dip;
   logic [6:0]  b_mod;
   // 8-bit instance
   logic        c_wr = 1'b0;
   logic [7:0]  c_idx = 8'd0;
   logic [26:0] c_addr = '0;
   logic [7:0]  c_data = '0;
   logic        c_owr, c_rom, c_busy, c_ovr;
   logic [24:0] c_oaddr;
   logic [7:0]  c_odata;
   logic [31:0] c_dip;
   logic [6:0]  c_mod;
`ifdef JTFRAME_IOCTL_CHKSUM_EN
   logic [15:0] a_sum, b_sum, c_sum;
`endif

   jtframe_ioctl_conv #(.DIN_W(16), .GAP(24)) dut16 (
      .clk_rom(clk), .rst_n(rst_n), .ioctl_download(dl), .ioctl_index(a_idx),
      .dwnld_wr(a_wr), .dwnld_addr(a_addr), .dwnld_data(a_data),
      .ioctl_wr(a_owr), .ioctl_addr(a_oaddr), .ioctl_data(a_odata),
      .ioctl_rom_wr(a_rom), .dipsw(a_dip), .core_mod(a_mod), .busy(a_busy),
      .overrun(a_ovr)
`ifdef JTFRAME_IOCTL_CHKSUM_EN
      , .chksum(a_sum)
`endif
   );

   jtframe_ioctl_conv #(.DIN_W(32), .GAP(3)) dut32 (
      .clk_rom(clk), .rst_n(rst_n), .ioctl_download(dl), .ioctl_index(b_idx),
      .dwnld_wr(b_wr), .dwnld_addr(b_addr), .dwnld_data(b_data),
      .ioctl_wr(b_owr), .ioctl_addr(b_oaddr), .ioctl_data(b_odata),
      .ioctl_rom_wr(b_rom), .dipsw(b_dip), .core_mod(b_mod), .busy(b_busy),
      .overrun(b_ovr)
`ifdef JTFRAME_IOCTL_CHKSUM_EN
      , .chksum(b_sum)
`endif
   );

   jtframe_ioctl_conv #(.DIN_W(8), .GAP(24)) dut8 (
      .clk_rom(clk), .rst_n(rst_n), .ioctl_download(dl), .ioctl_index(c_idx),
      .dwnld_wr(c_wr), .dwnld_addr(c_addr), .dwnld_data(c_data),
      .ioctl_wr(c_owr), .ioctl_addr(c_oaddr), .ioctl_data(c_odata),
      .ioctl_rom_wr(c_rom), .dipsw(c_dip), .core_mod(c_mod), .busy(c_busy),
      .overrun(c_ovr)
`ifdef JTFRAME_IOCTL_CHKSUM_EN
      , .chksum(c_sum)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_vec++; if (a_owr !== 1'b0) begin n_miss++; $display("FAIL reset_wr got=%0h exp=0", a_owr); end
      n_vec++; if (a_oaddr !== 25'd0) begin n_miss++; $display("FAIL reset_addr got=%0h exp=0", a_oaddr); end
      n_vec++; if (a_odata !== 8'd0) begin n_miss++; $display("FAIL reset_data got=%0h exp=0", a_odata); end
      n_vec++; if (a_rom !== 1'b0) begin n_miss++; $display("FAIL reset_rom_wr got=%0h exp=0", a_rom); end
      n_vec++; if (a_dip !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL reset_dipsw got=%0h exp=ffffffff", a_dip); end
      n_vec++; if (a_mod !== 7'h7F) begin n_miss++; $display("FAIL reset_core_mod got=%0h exp=7f", a_mod); end
      n_vec++; if (a_busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%0h exp=0", a_busy); end
      n_vec++; if (a_ovr !== 1'b0) begin n_miss++; $display("FAIL reset_overrun got=%0h exp=0", a_ovr); end
`ifdef JTFRAME_IOCTL_CHKSUM_EN
      n_vec++; if (c_sum !== 16'h0) begin n_miss++; $display("FAIL reset_chksum got=%0h exp=0", c_sum); end
`endif
      rst_n = 1'b1;
      dl = 1'b1;
      repeat (2) tick();
   endtask

   // Word BEEF, a pending word 1234 five cycles later, a dropped word after that
   task automatic test_rom_word();
      int          np;
      int          rom_bad;
      int          pc[8];
      logic [24:0] pa[8];
      logic [7:0]  pd[8];
      int          ec[4];
      logic [24:0] ea[4];
      logic [7:0]  ed[4];
      ec = '{1, 25, 49, 73};
      ea = '{25'h100, 25'h101, 25'h200, 25'h201};
      ed = '{8'hEF, 8'hBE, 8'h34, 8'h12};
      np = 0;
      rom_bad = 0;
      a_idx = 8'd0;
      for (int c = 0; c < 100; c++) begin
         a_wr = (c == 0) || (c == 5) || (c == 6);
         if (c == 0) begin a_addr = 27'h100; a_data = 16'hBEEF; end
         if (c == 5) begin a_addr = 27'h200; a_data = 16'h1234; end
         if (c == 6) begin a_addr = 27'h300; a_data = 16'h5678; end
         tick();
         a_wr = 1'b0;
         if (a_owr === 1'b1) begin
            if (np < 8) begin pc[np] = c + 1; pa[np] = a_oaddr; pd[np] = a_odata; end
            np++;
         end
         if (a_rom !== a_owr) rom_bad++;
         if (c + 1 == 6) begin
            n_vec++; if (a_busy !== 1'b1) begin n_miss++; $display("FAIL pend_busy got=%0h exp=1", a_busy); end
            n_vec++; if (a_ovr !== 1'b0) begin n_miss++; $display("FAIL pend_no_overrun got=%0h exp=0", a_ovr); end
         end
         if (c + 1 == 7) begin
            n_vec++; if (a_ovr !== 1'b1) begin n_miss++; $display("FAIL drop_overrun got=%0h exp=1", a_ovr); end
         end
      end
      n_vec++; if (np !== 4) begin n_miss++; $display("FAIL rom_pulse_count got=%0d exp=4", np); end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (pc[i] !== ec[i] || pa[i] !== ea[i] || pd[i] !== ed[i]) begin
            n_miss++;
            $display("FAIL rom_byte%0d got cyc=%0d addr=%0h data=%0h exp cyc=%0d addr=%0h data=%0h",
                     i, pc[i], pa[i], pd[i], ec[i], ea[i], ed[i]);
         end
      end
      n_vec++; if (rom_bad !== 0) begin n_miss++; $display("FAIL rom_wr_gating got=%0d bad cycles exp=0", rom_bad); end
      n_vec++; if (a_busy !== 1'b0) begin n_miss++; $display("FAIL rom_idle_busy got=%0h exp=0", a_busy); end
      n_vec++; if (a_ovr !== 1'b1) begin n_miss++; $display("FAIL overrun_sticky got=%0h exp=1", a_ovr); end
   endtask

   task automatic test_overrun_clear();
      dl = 1'b0;
      tick();
      n_vec++; if (a_ovr !== 1'b1) begin n_miss++; $display("FAIL overrun_dl_fall got=%0h exp=1", a_ovr); end
      dl = 1'b1;
      repeat (2) tick();
      n_vec++; if (a_ovr !== 1'b0) begin n_miss++; $display("FAIL overrun_dl_rise got=%0h exp=0", a_ovr); end
   endtask

   task automatic test_core_mod();
      a_idx = 8'd1; a_addr = 27'h0; a_data = 16'hFF05; a_wr = 1'b1;
      tick();
      a_wr = 1'b0;
      tick();
      n_vec++; if (a_mod !== 7'h05) begin n_miss++; $display("FAIL core_mod_byte0 got=%0h exp=05", a_mod); end
      repeat (80) tick();
      n_vec++; if (a_mod !== 7'h05) begin n_miss++; $display("FAIL core_mod_byte1 got=%0h exp=05", a_mod); end
      a_addr = 27'h2; a_data = 16'h1111; a_wr = 1'b1;
      tick();
      a_wr = 1'b0;
      repeat (80) tick();
      n_vec++; if (a_mod !== 7'h05) begin n_miss++; $display("FAIL core_mod_addr2 got=%0h exp=05", a_mod); end
   endtask

   // 32-bit DIP words: aligned, out of range, and with ignored low address bits
   task automatic dip_word(input logic [26:0] addr, input logic [31:0] data,
                           output int np, output int nrom, output logic [24:0] last_addr);
      np = 0; nrom = 0; last_addr = '0;
      b_idx = 8'd254; b_addr = addr; b_data = data;
      for (int c = 0; c < 16; c++) begin
         b_wr = (c == 0);
         tick();
         b_wr = 1'b0;
         if (b_owr === 1'b1) begin np++; last_addr = b_oaddr; end
         if (b_rom === 1'b1) nrom++;
      end
   endtask

   task automatic test_dip();
      int np, nrom;
      logic [24:0] la;
      dip_word(27'h0, 32'h0403_0201, np, nrom, la);
      n_vec++; if (np !== 4) begin n_miss++; $display("FAIL dip_pulses got=%0d exp=4", np); end
      n_vec++; if (nrom !== 0) begin n_miss++; $display("FAIL dip_rom_wr got=%0d exp=0", nrom); end
      n_vec++; if (b_dip !== 32'h0403_0201) begin n_miss++; $display("FAIL dip_value got=%0h exp=04030201", b_dip); end
      dip_word(27'h4, 32'hAABB_CCDD, np, nrom, la);
      n_vec++; if (la !== 25'h7) begin n_miss++; $display("FAIL dip_hi_last_addr got=%0h exp=7", la); end
      n_vec++; if (b_dip !== 32'h0403_0201) begin n_miss++; $display("FAIL dip_hi_ignored got=%0h exp=04030201", b_dip); end
      dip_word(27'h3, 32'h0A0B_0C0D, np, nrom, la);
      n_vec++; if (b_dip !== 32'h0A0B_0C0D) begin n_miss++; $display("FAIL dip_lowbits got=%0h exp=0a0b0c0d", b_dip); end
   endtask

   task automatic test_reset_mid();
      int np;
      a_idx = 8'd0; a_addr = 27'h10; a_data = 16'hAA55; a_wr = 1'b1;
      tick();
      a_wr = 1'b0;
      n_vec++; if (a_owr !== 1'b1 || a_odata !== 8'h55) begin n_miss++; $display("FAIL mid_byte0 got wr=%0h data=%0h exp wr=1 data=55", a_owr, a_odata); end
      a_data = 16'h7777; a_addr = 27'h20; a_wr = 1'b1;
      tick();
      a_wr = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      n_vec++; if (a_busy !== 1'b0) begin n_miss++; $display("FAIL mid_reset_busy got=%0h exp=0", a_busy); end
      repeat (2) tick();
      rst_n = 1'b1;
      np = 0;
      repeat (60) begin
         tick();
         if (a_owr === 1'b1) np++;
      end
      n_vec++; if (np !== 0) begin n_miss++; $display("FAIL mid_no_wr got=%0d pulses exp=0", np); end
      n_vec++; if (b_dip !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL mid_dipsw got=%0h exp=ffffffff", b_dip); end
      n_vec++; if (a_mod !== 7'h7F) begin n_miss++; $display("FAIL mid_core_mod got=%0h exp=7f", a_mod); end
`ifdef JTFRAME_IOCTL_CHKSUM_EN
      n_vec++; if (c_sum !== 16'h0) begin n_miss++; $display("FAIL mid_chksum got=%0h exp=0", c_sum); end
`endif
   endtask

   // 8-bit pass-through: back-to-back bytes 1,2,3 one cycle apart
   task automatic test_pass8();
      int np;
      int bad;
      np = 0; bad = 0;
      c_idx = 8'd0;
      for (int c = 0; c < 6; c++) begin
         c_wr = (c < 3);
         c_addr = 27'(27'h40 + c);
         c_data = 8'(c + 1);
         tick();
         c_wr = 1'b0;
         if (c < 3) begin
            if (c_owr !== 1'b1 || c_rom !== 1'b1 || c_oaddr !== 25'(25'h40 + c) || c_odata !== 8'(c + 1))
               bad++;
         end
         if (c_owr === 1'b1) np++;
      end
      n_vec++; if (np !== 3) begin n_miss++; $display("FAIL pass8_count got=%0d exp=3", np); end
      n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL pass8_bytes got=%0d bad bytes exp=0", bad); end
`ifdef JTFRAME_IOCTL_CHKSUM_EN
      n_vec++; if (c_sum !== 16'h0006) begin n_miss++; $display("FAIL pass8_chksum got=%0h exp=0006", c_sum); end
`endif
   endtask

   initial begin
      test_reset();
      test_rom_word();
      test_overrun_clear();
      test_core_mod();
      test_dip();
      test_reset_mid();
      test_pass8();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
